// File: rtl/mem_access_ctrl_pkg.sv
// Purpose: shared access-type encodings, FSM states and address helpers for the MEM-stage load/store path.
// Latency: n/a (types, constants and combinational helper functions only).
// Backpressure: n/a.
package mem_access_ctrl_pkg;

  // Access-type encodings as carried on u_b_h_w
  localparam logic [2:0] BYTE          = 3'b000;
  localparam logic [2:0] HALF          = 3'b001;
  localparam logic [2:0] WORD          = 3'b010;
  localparam int         UNSIGNED_BIT  = 2;
  localparam logic [2:0] BYTE_UNSIGNED = BYTE | 3'b100;

  // Data RAM decodes this many low address bits; bytes above the window read 0
  localparam int RAM_ADDR_BITS = 7;

  typedef enum logic {IDLE, SPLIT} state_t;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned
  function automatic logic is_misaligned(input logic [31:0] a, input logic [2:0] acc);
    if ((acc & WORD) != 3'b000) return a[1:0] != 2'b00;
    else if ((acc & HALF) != 3'b000) return a[0];
    else return 1'b0;
  endfunction

  // Index of the final byte of a split access (N-1)
  function automatic logic [1:0] last_idx(input logic [2:0] acc);
    return ((acc & WORD) != 3'b000) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Purpose: sign/zero extends a 1-, 2- or 4-byte little-endian load value to 32 bits.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mem_load_ext (
  input  logic [2:0]  nbytes,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  // Replicate the top bit of the loaded value unless the access is unsigned
  always_comb begin
    result = raw;
    case (nbytes)
      3'd1:    result = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      3'd2:    result = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Purpose: MEM-stage load/store controller; passes aligned accesses to the RAM, splits misaligned ones into bytes.
// Latency: aligned = 0 added cycles; misaligned = N cycles (N=2 half, N=4 word) with stall high for N-1.
// Backpressure: stall freezes the pipeline while a split is in flight; upstream holds request inputs stable.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  u_b_h_w,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic [2:0]  ram_u_b_h_w,
  input  logic [31:0] ram_dout
);

  state_t          state, state_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [3:0][7:0] byte_buf;
  logic            cap_en;
  logic            req;
  logic            misaligned;
  logic            last;
  logic [2:0]      nbytes;
  logic [31:0]     assembled;
  logic [31:0]     ext_result;

  assign req        = mem_re | mem_we;
  assign misaligned = is_misaligned(addr, u_b_h_w);
  assign nbytes     = u_b_h_w[1] ? 3'd4 : 3'd2;
  assign last       = (idx == last_idx(u_b_h_w));

  // Splice the byte arriving this cycle onto the bytes captured earlier
  always_comb begin
    assembled = byte_buf;
    assembled[{idx, 3'b000} +: 8] = ram_dout[7:0];
  end

  mem_load_ext u_ext (
    .nbytes      (nbytes),
    .is_unsigned (u_b_h_w[UNSIGNED_BIT]),
    .raw         (assembled),
    .result      (ext_result)
  );

  // State, byte index and captured-byte register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      byte_buf <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cap_en) byte_buf[idx] <= ram_dout[7:0];
    end
  end

  // Next-state and RAM-side outputs; defaults give the aligned pass-through
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cap_en         = 1'b0;
    ram_addr       = addr;
    ram_din        = wdata;
    ram_we         = mem_we;
    ram_u_b_h_w    = u_b_h_w;
    rdata          = ram_dout;
    stall          = 1'b0;
    misaligned_err = 1'b0;
    case (state)
      IDLE: begin
        if (req && misaligned) begin
          if (SPLIT_EN) begin
            // First byte goes out now; remaining bytes follow in SPLIT
            ram_u_b_h_w = BYTE_UNSIGNED;
            ram_din     = {24'b0, wdata[7:0]};
            stall       = 1'b1;
            cap_en      = 1'b1;
            state_nxt   = SPLIT;
            idx_nxt     = 2'd1;
          end else begin
            ram_we         = 1'b0;
            misaligned_err = 1'b1;
            rdata          = '0;
          end
        end
      end
      SPLIT: begin
        ram_addr    = addr + {30'b0, idx};
        ram_din     = {24'b0, wdata[{idx, 3'b000} +: 8]};
        ram_u_b_h_w = BYTE_UNSIGNED;
        cap_en      = 1'b1;
        if (last) begin
          rdata     = ext_result;
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
        end else begin
          stall   = 1'b1;
          idx_nxt = idx + 2'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
      end
    endcase
    // Reset abandons any split in flight without touching further bytes
    if (rst) begin
      ram_we         = 1'b0;
      stall          = 1'b0;
      misaligned_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose: self-checking bench for mem_access_ctrl with a byte-array RAM model and a reference memory image.
// Latency: n/a.
// Backpressure: bench holds request inputs stable while stall is high.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int RAM_BYTES = 1 << RAM_ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1;
  logic        mem_re = 1'b0, mem_we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  u_b_h_w = '0;
  logic [31:0] rdata, ram_addr, ram_din, ram_dout;
  logic        stall, misaligned_err, ram_we;
  logic [2:0]  ram_u_b_h_w;

  logic        ns_re = 1'b0, ns_we = 1'b0;
  logic [31:0] ns_addr = '0, ns_wdata = '0;
  logic [2:0]  ns_t = '0;
  logic [31:0] ns_rdata, ns_ram_addr, ns_ram_din;
  logic        ns_stall, ns_err, ns_ram_we;
  logic [2:0]  ns_ram_t;
  logic [31:0] ns_ram_dout = 32'hA5A5A5A5;

  logic [7:0]  ram [0:RAM_BYTES-1];
  logic [7:0]  ref_mem [0:RAM_BYTES-1];
  int          ram_n;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .addr(addr), .wdata(wdata),
    .u_b_h_w(u_b_h_w), .rdata(rdata), .stall(stall), .misaligned_err(misaligned_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_u_b_h_w(ram_u_b_h_w),
    .ram_dout(ram_dout)
  );

  mem_access_ctrl #(.SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .mem_re(ns_re), .mem_we(ns_we), .addr(ns_addr), .wdata(ns_wdata),
    .u_b_h_w(ns_t), .rdata(ns_rdata), .stall(ns_stall), .misaligned_err(ns_err),
    .ram_addr(ns_ram_addr), .ram_din(ns_ram_din), .ram_we(ns_ram_we), .ram_u_b_h_w(ns_ram_t),
    .ram_dout(ns_ram_dout)
  );

  // Byte-addressed RAM: combinational read with its own extension, writes on negedge
  always_comb begin
    logic [31:0] raw;
    logic [31:0] ai;
    ram_n = ram_u_b_h_w[1] ? 4 : (ram_u_b_h_w[0] ? 2 : 1);
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      ai = ram_addr + 32'(i);
      if (i < ram_n && ai < 32'(RAM_BYTES)) raw[8*i +: 8] = ram[ai[6:0]];
    end
    ram_dout = raw;
    if (!ram_u_b_h_w[2] && ram_n == 1) ram_dout = {{24{raw[7]}}, raw[7:0]};
    if (!ram_u_b_h_w[2] && ram_n == 2) ram_dout = {{16{raw[15]}}, raw[15:0]};
  end

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < RAM_BYTES; i++) ram[i] <= 8'h00;
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (i < ram_n && (ram_addr + 32'(i)) < 32'(RAM_BYTES))
          ram[7'(ram_addr + 32'(i))] <= ram_din[8*i +: 8];
    end
  end

  // Upstream protocol: request inputs never change in a cycle following a stall
  logic        prev_stall = 1'b0;
  logic [69:0] prev_req = '0;
  always @(posedge clk) begin
    #3;
    if (prev_stall === 1'b1 && {mem_re, mem_we, addr, wdata, u_b_h_w} !== prev_req) begin
      failures++;
      $display("FAIL protocol: request changed while stalled, now %h was %h",
               {mem_re, mem_we, addr, wdata, u_b_h_w}, prev_req);
    end
    prev_stall = stall;
    prev_req   = {mem_re, mem_we, addr, wdata, u_b_h_w};
  end

  // ---------------- reference model (size/alignment arithmetic on a byte image) -------------
  function automatic int nb(input logic [2:0] t);
    return t[1] ? 4 : (t[0] ? 2 : 1);
  endfunction

  function automatic bit mis(input logic [31:0] a, input logic [2:0] t);
    return (a % 32'(nb(t))) != 32'd0;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    logic [31:0] ai;
    for (int i = 0; i < nb(t); i++) begin
      ai = a + 32'(i);
      if (ai < 32'(RAM_BYTES)) ref_mem[ai[6:0]] = d[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
    longint      v = 0;
    int          n = nb(t);
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      if (ai < 32'(RAM_BYTES)) v += longint'(ref_mem[ai[6:0]]) << (8*i);
    end
    if (!t[2] && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < RAM_BYTES; i++) if (ram[i] !== ref_mem[i]) return i;
    return -1;
  endfunction

  // One request held until stall drops; returns cycles taken and rdata of the final cycle
  task automatic run_op(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] t, output int cyc, output logic [31:0] rd);
    logic st;
    @(posedge clk); #1;
    mem_we = we; mem_re = re; addr = a; wdata = d; u_b_h_w = t;
    cyc = 0; rd = '0;
    forever begin
      #2;
      cyc++; rd = rdata; st = stall;
      if (st !== 1'b1 || cyc >= 8) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_we = 1'b0; mem_re = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int d;
    for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; clr = 1'b1;
    mem_we = 1'b1; addr = 32'h0000_0008; wdata = 32'h1234_5678; u_b_h_w = WORD;
    repeat (2) @(posedge clk);
    #3;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (misaligned_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", misaligned_err); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    @(posedge clk); #1;
    rst = 1'b0; clr = 1'b0; mem_we = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall: got %b want 0", stall); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL idle_ram_we: got %b want 0", ram_we); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL reset_mem: first diff at %0d", d); end
  endtask

  task automatic test_aligned();
    int cyc; logic [31:0] rd; int d;
    run_op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, WORD, cyc, rd);
    ref_store(32'h10, 32'hDEADBEEF, WORD);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL aligned_st_cyc: got %0d want 1", cyc); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL aligned_st_mem: first diff at %0d", d); end
    run_op(1'b0, 1'b1, 32'h10, 32'h0, WORD, cyc, rd);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL aligned_ld_cyc: got %0d want 1", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL aligned_ld_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_misaligned_word();
    int cyc; logic [31:0] rd; logic [31:0] bytes;
    run_op(1'b1, 1'b0, 32'h21, 32'h11223344, WORD, cyc, rd);
    ref_store(32'h21, 32'h11223344, WORD);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL mis_st_cyc: got %0d want 4", cyc); end
    bytes = {ram[8'h24], ram[8'h23], ram[8'h22], ram[8'h21]};
    checks++; if (bytes !== 32'h11223344) begin failures++; $display("FAIL mis_st_bytes: got %h want 11223344", bytes); end
    run_op(1'b0, 1'b1, 32'h21, 32'h0, WORD, cyc, rd);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL mis_ld_cyc: got %0d want 4", cyc); end
    checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL mis_ld_data: got %h want 11223344", rd); end
  endtask

  task automatic test_half_sign();
    int cyc; logic [31:0] rd;
    run_op(1'b1, 1'b0, 32'h31, 32'h80, BYTE, cyc, rd);
    ref_store(32'h31, 32'h80, BYTE);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL byte_st_cyc: got %0d want 1", cyc); end
    run_op(1'b1, 1'b0, 32'h32, 32'hFF, BYTE, cyc, rd);
    ref_store(32'h32, 32'hFF, BYTE);
    run_op(1'b0, 1'b1, 32'h31, 32'h0, HALF, cyc, rd);
    checks++; if (cyc !== 2) begin failures++; $display("FAIL half_s_cyc: got %0d want 2", cyc); end
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL half_s_data: got %h want ffffff80", rd); end
    run_op(1'b0, 1'b1, 32'h31, 32'h0, HALF | 3'b100, cyc, rd);
    checks++; if (rd !== 32'h0000FF80) begin failures++; $display("FAIL half_u_data: got %h want 0000ff80", rd); end
  endtask

  task automatic test_wrap();
    int cyc; logic [31:0] rd; int d;
    run_op(1'b1, 1'b0, 32'h7E, 32'hAABBCCDD, WORD, cyc, rd);
    ref_store(32'h7E, 32'hAABBCCDD, WORD);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL wrap_st_cyc: got %0d want 4", cyc); end
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL wrap_st_mem: first diff at %0d", d); end
    run_op(1'b0, 1'b1, 32'h7E, 32'h0, WORD, cyc, rd);
    checks++; if (rd !== 32'h0000CCDD) begin failures++; $display("FAIL wrap_ld_data: got %h want 0000ccdd", rd); end
  endtask

  task automatic test_reset_mid_split();
    int d;
    @(posedge clk); #1;
    mem_we = 1'b1; mem_re = 1'b0; addr = 32'h41; wdata = 32'h55667788; u_b_h_w = WORD;
    #2;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rsplit_stall0: got %b want 1", stall); end
    @(posedge clk); #3;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rsplit_stall1: got %b want 1", stall); end
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rsplit_rst_stall: got %b want 0", stall); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rsplit_rst_we: got %b want 0", ram_we); end
    @(posedge clk); #1;
    rst = 1'b0; mem_we = 1'b0; mem_re = 1'b1; addr = 32'h41; u_b_h_w = BYTE;
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rsplit_idle_stall: got %b want 0", stall); end
    checks++; if (ram_addr !== 32'h41) begin failures++; $display("FAIL rsplit_idle_addr: got %h want 00000041", ram_addr); end
    checks++; if (rdata !== 32'hFFFFFF88) begin failures++; $display("FAIL rsplit_idle_rdata: got %h want ffffff88", rdata); end
    @(posedge clk); #1;
    mem_re = 1'b0;
    ref_mem[8'h41] = 8'h88;
    ref_mem[8'h42] = 8'h77;
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL rsplit_mem: first diff at %0d", d); end
  endtask

  task automatic test_split_disabled();
    @(posedge clk); #1;
    ns_re = 1'b1; ns_we = 1'b0; ns_addr = 32'h03; ns_t = HALF;
    #2;
    checks++; if (ns_err !== 1'b1) begin failures++; $display("FAIL nosplit_err: got %b want 1", ns_err); end
    checks++; if (ns_ram_we !== 1'b0) begin failures++; $display("FAIL nosplit_we: got %b want 0", ns_ram_we); end
    checks++; if (ns_stall !== 1'b0) begin failures++; $display("FAIL nosplit_stall: got %b want 0", ns_stall); end
    checks++; if (ns_rdata !== 32'h0) begin failures++; $display("FAIL nosplit_rdata: got %h want 0", ns_rdata); end
    @(posedge clk); #1;
    ns_re = 1'b0; ns_we = 1'b1; ns_addr = 32'h05; ns_wdata = 32'hCAFEF00D; ns_t = WORD;
    #2;
    checks++; if (ns_ram_we !== 1'b0) begin failures++; $display("FAIL nosplit_st_we: got %b want 0", ns_ram_we); end
    @(posedge clk); #1;
    ns_we = 1'b0; ns_re = 1'b1; ns_addr = 32'h04; ns_t = WORD;
    #2;
    checks++; if (ns_err !== 1'b0) begin failures++; $display("FAIL nosplit_aligned_err: got %b want 0", ns_err); end
    checks++; if (ns_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL nosplit_aligned_rdata: got %h want a5a5a5a5", ns_rdata); end
    @(posedge clk); #1;
    ns_re = 1'b0;
  endtask

  task automatic test_random();
    int cyc, exp_cyc, op, sel, d;
    logic [31:0] a, dat, rd, exp_rd;
    logic [2:0] t;
    logic we, re;
    for (int k = 0; k < 60; k++) begin
      a    = (k % 8 == 7) ? 32'($urandom_range(124, 127)) : 32'($urandom_range(0, 127));
      sel  = int'($urandom_range(0, 2));
      t[2] = 1'($urandom_range(0, 1));
      t[1] = (sel == 2);
      t[0] = (sel == 1);
      op   = int'($urandom_range(0, 2));
      we   = (op != 1);
      re   = (op != 0);
      dat  = $urandom;
      exp_cyc = mis(a, t) ? nb(t) : 1;
      exp_rd  = ref_load(a, t);
      run_op(we, re, a, dat, t, cyc, rd);
      checks++;
      if (cyc !== exp_cyc) begin
        failures++; $display("FAIL rand_cyc[%0d]: a=%h t=%b got %0d want %0d", k, a, t, cyc, exp_cyc);
      end
      if (we) begin
        ref_store(a, dat, t);
      end else begin
        checks++;
        if (rd !== exp_rd) begin
          failures++; $display("FAIL rand_rdata[%0d]: a=%h t=%b got %h want %h", k, a, t, rd, exp_rd);
        end
      end
      d = first_diff();
      checks++;
      if (d !== -1) begin failures++; $display("FAIL rand_mem[%0d]: first diff at %0d", k, d); end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned_word();
    test_half_sign();
    test_wrap();
    test_reset_mid_split();
    test_split_disabled();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage load/store controller sitting directly upstream of the byte-addressed data RAM.
- Takes the pipeline's load/store request and splits misaligned halfword/word accesses into byte accesses across consecutive cycles, stalling the pipeline meanwhile.
- Aligned accesses pass straight through in the same cycle.
- Sign/zero extension of split loads is done here; aligned loads take the RAM's own extension.

Parameters:
- SPLIT_EN, 1, 1 = split misaligned accesses; 0 = flag misaligned_err and suppress the access.

Ports:
- clk  in  1  core clock; RAM writes on its negedge
- rst  in  1  synchronous, active-high reset
- mem_re  in  1  load request
- mem_we  in  1  store request
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- u_b_h_w  in  3  access type: bit0 half, bit1 word, bit2 unsigned; bits[1:0]=00 is byte
- rdata  out  32  extended load result
- stall  out  1  freeze pipeline; request inputs held stable by upstream while high
- misaligned_err  out  1  single-cycle flag, SPLIT_EN=0 only
- ram_addr  out  32  to RAM address
- ram_din  out  32  to RAM write data
- ram_we  out  1  to RAM write enable
- ram_u_b_h_w  out  3  to RAM access type
- ram_dout  in  32  from RAM, combinational read

Behaviour:
- Reset: state IDLE, idx=0, byte buffer=0; stall=0, misaligned_err=0, ram_we=0.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Bytes are never misaligned. N=2 for half, N=4 for word.
- IDLE, no request (mem_re=mem_we=0): ram_we=0, stall=0, rdata=ram_dout (don't-care).
- IDLE, aligned request: combinational pass-through.
  - ram_addr=addr, ram_din=wdata, ram_we=mem_we, ram_u_b_h_w=u_b_h_w.
  - rdata=ram_dout, stall=0, zero added latency.
- IDLE, misaligned request, SPLIT_EN=1:
  - Issue byte 0: ram_addr=addr, ram_u_b_h_w=3'b100, ram_din={24'b0,wdata[7:0]}, ram_we=mem_we.
  - Capture ram_dout[7:0] into buf[0] at posedge.
  - stall=1; next state SPLIT, idx=1.
- SPLIT cycle idx (1..N-1):
  - ram_addr=addr+idx, using a full 32-bit add.
  - ram_din[7:0]=wdata[8*idx+7:8*idx], ram_u_b_h_w=3'b100.
  - buf[idx] captured at posedge.
  - idx<N-1: stall=1, idx++.
  - idx=N-1: stall=0; rdata=assembled {ram_dout[7:0], buf[N-2..0]}, sign-extended from bit 8N-1 unless u_b_h_w[2]. Next state IDLE.
- Latency: a misaligned access takes N cycles total, with stall high for N-1 of them. Each byte is written exactly once, at that cycle's negedge.
- Store+load both asserted: treated as store; rdata don't-care.
- SPLIT_EN=0 with a misaligned request: ram_we=0, misaligned_err=1 for that cycle, stall=0, rdata=0.
- Address wrap: addr+idx beyond the RAM window (0x7F→0x80) is not checked here. The RAM returns 0 / ignores writes for those bytes, and the split still completes in N cycles.
- Reset mid-SPLIT: next state IDLE, stall=0. Bytes already written stay written; remaining bytes are abandoned.
- Request inputs changing during SPLIT is an upstream protocol violation; the bench asserts it never happens.

Decomposition:
- Shared package:
  - Access-type encodings: BYTE=3'b000, HALF=3'b001, WORD=3'b010, UNSIGNED bit=2.
  - State enum {IDLE, SPLIT}.
  - RAM window constant RAM_ADDR_BITS=7.
- One natural sub-module, mem_load_ext: combinational sign/zero extender (byte count, unsigned flag, 32-bit raw → 32-bit result). Reusable elsewhere in the core.

Test Plan:
- Aligned word store 0xDEADBEEF @0x10, then aligned load → stall never high; rdata=0xDEADBEEF same cycle.
- Misaligned word store 0x11223344 @0x21 → stall high 3 cycles; RAM bytes 0x21..0x24 = 44,33,22,11. Then misaligned signed load @0x21 → 4 cycles, rdata=0x11223344.
- Store byte 0x80 @0x31 and 0xFF @0x32; signed half load @0x31 → rdata=0xFFFFFF80 after 2 cycles; unsigned half load → 0x0000FF80.
- Word store 0xAABBCCDD @0x7E → bytes 0x7E=DD, 0x7F=CC written, 0x80/0x81 ignored; subsequent load @0x7E → rdata=0x0000CCDD.
- rst asserted at idx=2 of a misaligned word store @0x41 → next cycle IDLE, stall=0; only bytes 0x41, 0x42 modified.
- SPLIT_EN=0, half load @0x03 → misaligned_err=1 one cycle, ram_we=0, stall=0, rdata=0.
